// File: rtl/countdown_bcd_if.sv
// Control and display bundle for the countdown_bcd timer core.
// The master drives load/start/stop; the slave (the timer) drives digits and status.
interface countdown_bcd_if;
  logic        LOAD;
  logic [15:0] LOAD_VAL;
  logic        START;
  logic        STOP;
  logic [3:0]  M1;
  logic [3:0]  M0;
  logic [3:0]  S1;
  logic [3:0]  S0;
  logic        RUNNING;
  logic        DONE;

  modport master (
    output LOAD, LOAD_VAL, START, STOP,
    input  M1, M0, S1, S0, RUNNING, DONE
  );

  modport slave (
    input  LOAD, LOAD_VAL, START, STOP,
    output M1, M0, S1, S0, RUNNING, DONE
  );
endinterface

// File: rtl/countdown_bcd.sv
// MM:SS BCD countdown timer: decrements once per TICK_DIV clocks while running,
// stops and raises a sticky DONE when counting reaches 00:00.
module countdown_bcd #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic           CLK,
  input  logic           RST,
  countdown_bcd_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  // RUNNING is the FSM state itself, so the state is always visible on the bus.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [3:0]    m1, m0, s1, s0;
  logic          done;

  logic [3:0]    d_m1, d_m0, d_s1, d_s0;
  logic          dec_zero;
  logic          is_zero;
  logic [3:0]    l_m1, l_m0, l_s1, l_s0;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    l_m1 = clamp(bus.LOAD_VAL[15:12], 4'd9);
    l_m0 = clamp(bus.LOAD_VAL[11:8],  4'd9);
    l_s1 = clamp(bus.LOAD_VAL[7:4],   4'd5);
    l_s0 = clamp(bus.LOAD_VAL[3:0],   4'd9);
  end

  // One-second BCD decrement with borrow chain S0 -> S1 -> M0 -> M1.
  always_comb begin
    d_m1 = m1;
    d_m0 = m0;
    d_s1 = s1;
    d_s0 = s0 - 4'd1;
    if (s0 == 4'd0) begin
      d_s0 = 4'd9;
      if (s1 == 4'd0) begin
        d_s1 = 4'd5;
        if (m0 == 4'd0) begin
          d_m0 = 4'd9;
          d_m1 = m1 - 4'd1;
        end else begin
          d_m0 = m0 - 4'd1;
        end
      end else begin
        d_s1 = s1 - 4'd1;
      end
    end
    dec_zero = ({d_m1, d_m0, d_s1, d_s0} == 16'h0000);
    is_zero  = ({m1, m0, s1, s0} == 16'h0000);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pre   <= '0;
      done  <= 1'b0;
      m1    <= 4'd0;
      m0    <= 4'd0;
      s1    <= 4'd0;
      s0    <= 4'd0;
    end else if (bus.LOAD) begin
      state <= IDLE;
      pre   <= '0;
      done  <= 1'b0;
      m1    <= l_m1;
      m0    <= l_m0;
      s1    <= l_s1;
      s0    <= l_s0;
    end else if (bus.STOP) begin
      // pre is kept so a resume continues the partial second.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START && !is_zero) begin
            state <= RUN;
            if (done) pre <= '0;
          end
        end
        RUN: begin
          if (pre == PRE_MAX) begin
            pre <= '0;
            m1  <= d_m1;
            m0  <= d_m0;
            s1  <= d_s1;
            s0  <= d_s0;
            if (dec_zero) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.M1      = m1;
  assign bus.M0      = m0;
  assign bus.S1      = s1;
  assign bus.S0      = s0;
  assign bus.RUNNING = (state == RUN);
  assign bus.DONE    = done;

endmodule

// File: tb/tb_countdown_bcd.sv
// Bench for countdown_bcd: directed test-plan sequences plus random control,
// each cycle compared against a seconds-count reference model.
module tb_countdown_bcd;

  localparam int TD = 4;

  logic CLK;
  logic RST;
  countdown_bcd_if bus ();

  countdown_bcd #(.TICK_DIV(TD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: time held as a plain seconds count
  int m_secs;
  int m_pre;
  bit m_run;
  bit m_done;

  int checks;
  int failures;
  logic [17:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] secs_to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int load_to_secs(input logic [15:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(v[15 - 4*i -: 4]);
      if (d[i] > 9) d[i] = 9;
    end
    if (d[2] > 5) d[2] = 5;
    return (d[0] * 10 + d[1]) * 60 + d[2] * 10 + d[3];
  endfunction

  task automatic model_edge(input bit rst, input bit load, input logic [15:0] val,
                            input bit start, input bit stop);
    if (rst) begin
      m_secs = 0; m_run = 0; m_done = 0; m_pre = 0;
    end else if (load) begin
      m_secs = load_to_secs(val); m_run = 0; m_done = 0; m_pre = 0;
    end else if (stop) begin
      m_run = 0;
    end else if (start && !m_run) begin
      if (m_secs != 0) begin
        m_run = 1;
        if (m_done) m_pre = 0;
      end
    end else if (m_run) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  // driver: apply inputs, clock one edge, advance model, compare #1 after edge
  task automatic step(input bit rst, input bit load, input logic [15:0] val,
                      input bit start, input bit stop);
    logic [17:0] exp_w;
    logic [17:0] obs_w;
    RST = rst;
    bus.LOAD = load;
    bus.LOAD_VAL = val;
    bus.START = start;
    bus.STOP = stop;
    @(posedge CLK);
    model_edge(rst, load, val, start, stop);
    exp_q.push_back({secs_to_bcd(m_secs), m_run, m_done});
    #1;
    obs_w = {bus.M1, bus.M0, bus.S1, bus.S0, bus.RUNNING, bus.DONE};
    exp_w = exp_q.pop_front();
    check_val("digits", 32'(obs_w[17:2]), 32'(exp_w[17:2]));
    check_val("running", 32'(obs_w[1]), 32'(exp_w[1]));
    check_val("done", 32'(obs_w[0]), 32'(exp_w[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 0, 0);
  endtask

  function automatic logic [15:0] digits();
    return {bus.M1, bus.M0, bus.S1, bus.S0};
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    m_secs = 0; m_pre = 0; m_run = 0; m_done = 0;
    RST = 1'b1;
    bus.LOAD = 1'b0;
    bus.LOAD_VAL = 16'h0000;
    bus.START = 1'b0;
    bus.STOP = 1'b0;

    // reset with LOAD/START active
    step(1, 1, 16'h1234, 1, 0);
    step(1, 1, 16'h1234, 1, 0);
    check_val("rst_digits", 32'(digits()), 32'h0000);
    check_val("rst_running", 32'(bus.RUNNING), 32'd0);

    // borrow chain
    step(0, 1, 16'h1000, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    idle(TD);
    check_val("borrow_0959", 32'(digits()), 32'h0959);
    idle(TD);
    check_val("borrow_0958", 32'(digits()), 32'h0958);
    check_val("borrow_run", 32'(bus.RUNNING), 32'd1);

    // expiry
    step(0, 1, 16'h0002, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    idle(TD);
    check_val("exp_0001", 32'(digits()), 32'h0001);
    idle(TD);
    check_val("exp_0000", 32'(digits()), 32'h0000);
    check_val("exp_done", 32'(bus.DONE), 32'd1);
    step(0, 0, 16'h0000, 1, 0);
    check_val("exp_restart_done", 32'(bus.DONE), 32'd1);
    check_val("exp_restart_run", 32'(bus.RUNNING), 32'd0);

    // pause / resume keeps the partial second
    step(0, 1, 16'h0010, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    idle(2);
    step(0, 0, 16'h0000, 0, 1);
    idle(10);
    check_val("pause_hold", 32'(digits()), 32'h0010);
    step(0, 0, 16'h0000, 1, 0);
    idle(2);
    check_val("resume_0009", 32'(digits()), 32'h0009);

    // clamping
    step(0, 1, 16'hFA7C, 0, 0);
    check_val("clamp", 32'(digits()), 32'h9959);

    // simultaneous controls
    step(0, 0, 16'h0000, 1, 0);
    idle(3);
    step(0, 1, 16'h0130, 1, 0);
    check_val("load_start", 32'(digits()), 32'h0130);
    check_val("load_start_run", 32'(bus.RUNNING), 32'd0);
    step(0, 0, 16'h0000, 1, 0);
    idle(TD - 1);
    step(0, 0, 16'h0000, 1, 1);
    check_val("stop_start_run", 32'(bus.RUNNING), 32'd0);

    // mid-count reset
    step(0, 0, 16'h0000, 1, 0);
    idle(2);
    step(1, 0, 16'h0000, 0, 0);
    idle(TD + 1);
    check_val("midrst_digits", 32'(digits()), 32'h0000);

    // random control traffic, mostly short times so expiry is exercised
    for (int i = 0; i < 3000; i++) begin
      bit r, l, s, p;
      logic [15:0] v;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else v = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      step(r, l, v, s, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_bcd.md
# countdown_bcd

Countdown timer core for the ch06 countdown-timer design. It holds a four-digit BCD time value MM:SS and decrements it once per prescaled second while running. On reaching 00:00 it stops and flags completion. Each digit output is presented as a 4-bit BCD nibble to feed one instance of the downstream 7-segment decoder, directly or through the display multiplexer.

## Interface
Parameters:
- TICK_DIV, default 100_000_000: CLK cycles per countdown second. Must be ≥ 2. Benches use 4.

Ports:
- CLK, in, 1: system clock. All state updates on its rising edge.
- RST, in, 1: reset, synchronous and active-high.
- LOAD, in, 1: load LOAD_VAL into the digits.
- LOAD_VAL, in, 16: {M1, M0, S1, S0}, one BCD nibble each, M1 in bits [15:12].
- START, in, 1: begin or resume the countdown.
- STOP, in, 1: pause the countdown.
- M1, M0, S1, S0, out, 4 each: current BCD digits (minutes tens/units, seconds tens/units). Registered.
- RUNNING, out, 1: countdown active. Registered.
- DONE, out, 1: sticky flag, set when the count reaches 00:00 by counting. Registered.

## Operation
- State is the digits plus a 1-bit run flag (RUNNING) and a prescaler counter `pre` of width clog2(TICK_DIV).
  - IDLE/PAUSED: RUNNING=0.
  - RUN: RUNNING=1.
- Control priority within one cycle: RST > LOAD > STOP > START.
- RST: all digits 0, RUNNING=0, DONE=0, pre=0.
- LOAD (any state):
  - Digits are taken from LOAD_VAL with clamping: any nibble >9 loads as 9, and S1 >5 loads as 5.
  - RUNNING=0, DONE=0, pre=0.
- STOP: RUNNING=0. pre holds its value, so a later resume keeps the fractional second.
- START (no LOAD/STOP that cycle):
  - If digits ≠ 00:00 and RUNNING=0: RUNNING=1. pre is cleared to 0 only if DONE=1 or pre was never advanced since LOAD/RST; otherwise it holds.
  - If digits = 00:00: ignored, and DONE is unchanged.
  - If already RUNNING: no effect.
- While RUNNING:
  - If pre < TICK_DIV-1: pre increments.
  - If pre = TICK_DIV-1: pre → 0 and the time decrements by one second.
- Decrement (BCD borrow chain):
  - S0: 9→8…1→0. 0→9 with a borrow into S1.
  - S1: 5…0. 0→5 with a borrow into M0.
  - M0: 0→9 with a borrow into M1.
  - M1: decrements by the borrow. M1=0 never borrows, because a 00:00 value is never decremented.
- Expiry: if the decrement produces 00:00, then on the same edge RUNNING→0 and DONE→1.
- DONE stays high until RST or LOAD. START at 00:00 does not clear it.
- All arithmetic is per-digit 4-bit BCD. No binary-to-BCD conversion.

## Timing
- Every output is registered and changes only on a CLK rising edge.
- Reset values: M1=M0=S1=S0=0, RUNNING=0, DONE=0.
- LOAD sampled at edge n: digits valid, and RUNNING=0, after edge n.
- START sampled at edge n from a fresh load: RUNNING=1 after edge n, with pre=0.
  - The first decrement is visible after edge n+TICK_DIV.
  - Each further decrement follows every TICK_DIV cycles.
- STOP at edge n: RUNNING=0 after edge n. If pre=TICK_DIV-1 at edge n, no decrement occurs (STOP wins).
- Expiry: the edge that writes 00:00 also clears RUNNING and sets DONE. Zero added latency.
- LOAD and START asserted together: LOAD wins, RUNNING=0.
- Mid-count RST: outputs at reset values after that edge. No residual tick.

## Test plan
- Reset: hold RST 2 cycles with LOAD/START high → all digits 0, RUNNING=0, DONE=0.
- Load and borrow chain (TICK_DIV=4): LOAD 16'h1000, then START at edge 0.
  - After edge 4 the digits read 09:59.
  - After edge 8 they read 09:58.
  - RUNNING=1 throughout.
- Expiry (TICK_DIV=4): LOAD 16'h0002, then START.
  - After edge 4: 00:01.
  - After edge 8: 00:00, RUNNING=0, DONE=1.
  - A further START leaves DONE=1 and RUNNING=0.
- Pause/resume (TICK_DIV=4): LOAD 0010, START, STOP after 2 cycles, hold 10 cycles, then START.
  - The digits stay 00:10 while stopped.
  - 00:09 appears 2 cycles after the resume (pre retained).
- Clamping: LOAD 16'hFA7C → digits read 9,9,5,9 (99:59), RUNNING=0.
- Simultaneous events: while running, assert LOAD(16'h0130) and START in the same cycle → digits 01:30, RUNNING=0, DONE=0. STOP+START in the same cycle → RUNNING=0.
